// File: rtl/cmp_pkg.sv
// Shared types, constants and density scaling for the comparator density meter.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } cmp_state_t;

  localparam int WIN_BASE_LOG2 = 7;
  localparam int ONES_W        = 11;

  // ones*256/N for N = 128 << win_r, saturated so a full-high window reads 255.
  function automatic logic [7:0] density_scale(input logic [ONES_W-1:0] ones,
                                               input logic [1:0]        win_r);
    logic [ONES_W:0] v;
    case (win_r)
      2'd0:    v = {ones, 1'b0};
      2'd1:    v = {1'b0, ones};
      2'd2:    v = {2'b00, ones[ONES_W-1:1]};
      default: v = {3'b000, ones[ONES_W-1:2]};
    endcase
    return (v > (ONES_W+1)'(255)) ? 8'hff : v[7:0];
  endfunction

endpackage

// File: rtl/cmp_glitch_filter.sv
// Run-length glitch filter: q follows d only after filt_len+1 consecutive mismatching samples.
module cmp_glitch_filter
  import cmp_pkg::*;
#(
  parameter int FILT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d,
  input  logic [FILT_W-1:0] filt_len,
  output logic              q
);

  logic [FILT_W-1:0] run_cnt;

  // >= rather than == so a live reduction of filt_len cannot strand the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= 1'b0;
      run_cnt <= '0;
    end else if (d == q) begin
      run_cnt <= '0;
    end else if (run_cnt >= filt_len) begin
      q       <= d;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + FILT_W'(1);
    end
  end

endmodule

// File: rtl/cmp_density_meter.sv
// Comparator back-end: sync chain, optional glitch filter, windowed density/transition meter.
// Build option: define CMP_GLITCH_FILTER_EN to insert cmp_glitch_filter after the sync chain.
module cmp_density_meter
  import cmp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmp_in,
  input  logic [1:0]        win_sel,
  input  logic [FILT_W-1:0] filt_len,
  output logic              cmp_q,
  output logic [7:0]        density,
  output logic [7:0]        trans_cnt,
  output logic              res_vld,
  output logic              busy,
  output cmp_state_t        state
);

  // res_vld is a one-cycle strobe with no ready: density/trans_cnt are
  // updated on that cycle and hold until the next strobe.

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_q;
  logic [7:0]             settle_last;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_r <= '0;
    else        sync_r <= {sync_r[SYNC_STAGES-2:0], cmp_in};
  end
  assign s_q = sync_r[SYNC_STAGES-1];

  // The IDLE cycle that samples ena counts as the first discarded cycle, so
  // SETTLE lasts latency-1 cycles and RUN starts exactly when cmp_q is valid.
`ifdef CMP_GLITCH_FILTER_EN
  cmp_glitch_filter #(.FILT_W(FILT_W)) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (s_q),
    .filt_len (filt_len),
    .q        (cmp_q)
  );
  assign settle_last = 8'(SYNC_STAGES - 1) + 8'(filt_len);
`else
  logic unused_filt_len;
  assign unused_filt_len = ^filt_len;

  always_ff @(posedge clk) begin
    if (!rst_n) cmp_q <= 1'b0;
    else        cmp_q <= s_q;
  end
  assign settle_last = 8'(SYNC_STAGES - 1);
`endif

  cmp_state_t        state_r, state_n;
  logic              cmp_q_d;
  logic [7:0]        scnt;
  logic [9:0]        wcnt;
  logic [9:0]        win_last;
  logic [ONES_W-1:0] win_len;
  logic [1:0]        win_r;
  logic [ONES_W-1:0] ones, ones_nxt;
  logic [7:0]        tr, tr_nxt;
  logic              win_end;

  assign state    = state_r;
  assign busy     = (state_r != IDLE);
  assign win_len  = ONES_W'(1) << (WIN_BASE_LOG2 + int'(win_r));
  assign win_last = 10'(win_len - ONES_W'(1));
  assign win_end  = (state_r == RUN) && (wcnt == win_last);
  assign ones_nxt = ones + ONES_W'(cmp_q);
  assign tr_nxt   = ((cmp_q ^ cmp_q_d) && (tr != 8'hff)) ? tr + 8'd1 : tr;

  always_comb begin
    state_n = state_r;
    if (!ena) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_n = SETTLE;
        SETTLE:  if (scnt >= settle_last) state_n = RUN;
        RUN:     state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_q_d   <= 1'b0;
      res_vld   <= 1'b0;
      density   <= 8'd0;
      trans_cnt <= 8'd0;
      scnt      <= 8'd0;
      wcnt      <= 10'd0;
      win_r     <= 2'd0;
      ones      <= '0;
      tr        <= 8'd0;
    end else begin
      cmp_q_d <= cmp_q;
      res_vld <= 1'b0;
      if (state_r == RUN && ena) begin
        if (win_end) begin
          density   <= density_scale(ones_nxt, win_r);
          trans_cnt <= tr_nxt;
          res_vld   <= 1'b1;
          ones      <= '0;
          tr        <= 8'd0;
          wcnt      <= 10'd0;
          win_r     <= win_sel;
        end else begin
          ones <= ones_nxt;
          tr   <= tr_nxt;
          wcnt <= wcnt + 10'd1;
        end
      end else if (state_r == SETTLE && ena) begin
        scnt  <= scnt + 8'd1;
        win_r <= win_sel;
      end else begin
        scnt <= 8'd0;
        wcnt <= 10'd0;
        ones <= '0;
        tr   <= 8'd0;
      end
    end
  end

endmodule

// File: doc/cmp_density_meter.md
# cmp_density_meter

Digital back-end for the gate-built comparator on the analog pins. It re-times the comparator's asynchronous output into the clock domain and optionally glitch-filters it. Over a programmable window it measures the fraction of time the output is high (duty/density) and the number of output transitions. Each window ends with an 8-bit density code, an 8-bit transition count and a one-cycle valid strobe, which the top level routes to `uo_out`/`uio_out`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flop count, minimum 2.
- `FILT_W`, 3: width of the filter-length field.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: measurement enable; low forces IDLE.
- `cmp_in` in 1: raw comparator output, asynchronous to `clk`.
- `win_sel` in 2: window length N = 128 << `win_sel` (128/256/512/1024 cycles).
- `filt_len` in `FILT_W`: filter requires `filt_len`+1 consecutive equal samples.
- `cmp_q` out 1: synchronized, filtered comparator level.
- `density` out 8: high-time fraction of the last completed window, 0..255.
- `trans_cnt` out 8: transitions of `cmp_q` in the last completed window, saturating at 255.
- `res_vld` out 1: one-cycle strobe; `density`/`trans_cnt` updated this cycle.
- `busy` out 1: high in SETTLE or RUN.

## Operation
- Sync chain: `SYNC_STAGES` flops on `cmp_in`, producing `s_q`.
- Filter: 3-bit run counter compares `s_q` to `cmp_q`.
  - Counter clears on equality and increments on mismatch.
  - When the counter reaches `filt_len`, `cmp_q` takes `s_q` and the counter clears.
  - With `filt_len`=0, `cmp_q` follows `s_q` with one register delay.
- FSM states: IDLE, SETTLE, RUN.
  - IDLE: counters held at 0. `ena`=1 → SETTLE.
  - SETTLE: discards `SYNC_STAGES`+`filt_len`+1 cycles. Latches `win_sel` into `win_r`, then → RUN.
  - RUN: window counter counts 0..N-1.
    - `ones` accumulates `cmp_q`; it is 11 bits wide and can reach 1024.
    - `tr` accumulates `cmp_q` toggles and saturates at 255.
    - On count N-1: outputs load, `res_vld` pulses, the counters clear, `win_r` reloads from `win_sel` and RUN continues with no gap.
  - `ena`=0 in any state → IDLE next cycle. The partial window is discarded and `density`/`trans_cnt` hold their last values.
- Density scaling, using the `win_r` latched at window start (computed as `ones`·256/N):

  | `win_r` | Density |
  |---|---|
  | 0 | `ones`<<1 |
  | 1 | `ones` |
  | 2 | `ones`>>1 |
  | 3 | `ones`>>2 |

  - Saturate to 255, so a full-high window reads 255.
- Sampling rules for the transition count:
  - A transition is counted on the cycle when `cmp_q` changes.
  - Its sample goes into the window that contains that cycle.
  - The sample on the final cycle of a window is included in that window's totals.
- `win_sel` changes mid-window do not affect the current window.
- `filt_len` is used live; changing it mid-window is legal and alters only the filter.

## Timing
- Reset (`rst_n`=0 at a `clk` edge) sets the following to 0:
  - `cmp_q`, `density`, `trans_cnt`, `res_vld`, `busy`;
  - all sync flops;
  - all counters;
  - the FSM state, to IDLE.
- Reset mid-window behaves like reset at any other time: results clear to 0.
- `cmp_in` to `cmp_q` latency: `SYNC_STAGES`+`filt_len`+1 cycles.
- First `res_vld`: `SYNC_STAGES`+`filt_len`+1+N cycles after the first cycle with `ena`=1.
- Subsequent strobes: every N cycles.
- `res_vld` is exactly one cycle wide and never asserts in IDLE or SETTLE.
- Outputs are registered and change only on the `res_vld` cycle.
- `busy` is high from the cycle after `ena` rises through the cycle after `ena` falls.

## Configuration
- Macro `CMP_GLITCH_FILTER_EN`.
- Defined: the filter is built as described above.
- Undefined:
  - `cmp_q` = `s_q` registered once, as if `filt_len`=0;
  - the `filt_len` port is ignored;
  - SETTLE lasts `SYNC_STAGES`+1 cycles.

## Structure
- Shared package `cmp_pkg`:
  - FSM state enum `cmp_state_t` (IDLE, SETTLE, RUN);
  - constant `WIN_BASE_LOG2` = 7;
  - constant `ONES_W` = 11;
  - function `density_scale(ones, win_r)`.
- One sub-module: `cmp_glitch_filter` (`clk`, `rst_n`, `d`, `filt_len`, `q`). It is instantiated only under `CMP_GLITCH_FILTER_EN`.
- The sync chain, FSM and accumulators live in the parent.

## Test plan
- `cmp_in`=1 constant, `win_sel`=0, `filt_len`=0 → `res_vld` every 128 cycles after settle; `density`=255, `trans_cnt`=0 (first window may show 1).
- Square wave 8 cycles high / 8 low, `win_sel`=1 → `density`=128, `trans_cnt`=32 each window.
- 1-cycle high glitches every 16 cycles, `filt_len`=2, macro defined → `density`=0, `trans_cnt`=0. Same stimulus with the macro undefined → `density`=16 (`win_sel`=1), `trans_cnt`=32.
- `cmp_in` toggling every cycle, `filt_len`=0, `win_sel`=3 → `trans_cnt` saturates at 255; `density`=128.
- `ena` dropped at cycle 60 of a 128-cycle window → no `res_vld`, previous results held; re-enable → next strobe exactly settle+128 cycles later.
- `rst_n`=0 for one cycle mid-window with `density`=200 → next cycle all outputs 0 and state IDLE; `win_sel` change mid-window applies only from the following window.
